// File: rtl/tw_buf_seq_param_if.sv
// Twiddle buffer bus: read-side controls/outputs and the half-word load port.
// master = host/BFU side driving the controls, slave = the twiddle buffer.
interface tw_buf_seq_param_if #(
    parameter int DW       = 64,
    parameter int SC_WIDTH = 2
);
    logic                CEN;
    logic [SC_WIDTH-1:0] stage_counter;
    logic                adv;
    logic                ld_start;
    logic                ld_valid;
    logic [DW-1:0]       ld_data;
    logic                ld_done;
    logic [2*DW-1:0]     Q;
    logic                Q_valid;
    logic [2*DW-1:0]     Q_const;

    modport master (
        output CEN, stage_counter, adv, ld_start, ld_valid, ld_data,
        input  ld_done, Q, Q_valid, Q_const
    );

    modport slave (
        input  CEN, stage_counter, adv, ld_start, ld_valid, ld_data,
        output ld_done, Q, Q_valid, Q_const
    );
endinterface

// File: rtl/tw_buf_seq_param.sv
// Runtime-loadable twiddle-factor buffer for the radix-16 NTT pipeline.
// Table of NUM_STAGE x NUM_GROUP x DEPTH twiddle pairs {twiddle, pre-multiplied},
// loaded hi-then-lo through a DW-bit port and replayed one entry per enabled
// cycle with per-stage group rotation.
// Optional feature macro: TW_BUF_CONST_LOAD_EN -- when defined, the load
// sequence continues with one per-stage constant (hi then lo) after the table.
//
// state | meaning
// RUN   | table readable, load port idle until ld_start
// LOAD  | half-words written at ascending flat address, reads return identity
module tw_buf_seq_param #(
    parameter int DW        = 64,
    parameter int NUM_STAGE = 3,
    parameter int NUM_GROUP = 4,
    parameter int DEPTH     = 4,
    parameter int REPEAT    = 16
) (
    input logic               CLK,
    input logic               rst_n,
    tw_buf_seq_param_if.slave bus
);
    localparam int P_WIDTH  = 2 * DW;
    localparam int SC_WIDTH = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1;
    localparam int SCX      = SC_WIDTH + 1;
    localparam int ENTRIES  = NUM_STAGE * NUM_GROUP * DEPTH;
`ifdef TW_BUF_CONST_LOAD_EN
    localparam int TOTAL    = ENTRIES + NUM_STAGE;
`else
    localparam int TOTAL    = ENTRIES;
`endif
    localparam int AW       = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int LA_W     = $clog2(TOTAL + 1);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PASS_W   = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int GRP_W    = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1;

    localparam logic [P_WIDTH-1:0] IDENT = {DW'(1), DW'(1)};

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]          state;
    logic [LA_W-1:0]     ld_addr;
    logic                ld_half;
    logic                ld_done_r;
    logic                wr_en;

    logic [P_WIDTH-1:0]  entry_mem [ENTRIES];
`ifdef TW_BUF_CONST_LOAD_EN
    logic [P_WIDTH-1:0]  const_mem [NUM_STAGE];
    logic [SC_WIDTH-1:0] const_sel;
`endif

    logic [IDX_W-1:0]    idx;
    logic [PASS_W-1:0]   pass;
    logic [GRP_W-1:0]    grp [NUM_STAGE];
    logic [SC_WIDTH-1:0] stage_q;

    logic                in_range;
    logic                rd_en;
    logic                stage_chg;
    logic [SC_WIDTH-1:0] stage_sel;
    logic [IDX_W-1:0]    idx_eff;
    logic [PASS_W-1:0]   pass_eff;
    logic [GRP_W-1:0]    grp_cur;
    logic [AW-1:0]       rd_addr;
    logic [P_WIDTH-1:0]  const_nxt;

    logic [P_WIDTH-1:0]  q_r;
    logic                q_valid_r;
    logic [P_WIDTH-1:0]  q_const_r;

    // Read qualification and the table address of the entry due this cycle;
    // a new stage starts its pass from idx 0 on its first read.
    always_comb begin
        in_range  = ({1'b0, bus.stage_counter} < SCX'(NUM_STAGE));
        rd_en     = (state == ST_RUN) && !bus.CEN && in_range;
        stage_sel = in_range ? bus.stage_counter : '0;
        stage_chg = (bus.stage_counter != stage_q);
        idx_eff   = stage_chg ? '0 : idx;
        pass_eff  = stage_chg ? '0 : pass;
        grp_cur   = grp[stage_sel];
        rd_addr   = AW'((int'(stage_sel) * NUM_GROUP + int'(grp_cur)) * DEPTH + int'(idx_eff));
        wr_en     = (state == ST_LOAD) && !bus.ld_start && bus.ld_valid;
`ifdef TW_BUF_CONST_LOAD_EN
        const_sel = SC_WIDTH'(ld_addr - LA_W'(ENTRIES));
        const_nxt = const_mem[stage_sel];
`else
        const_nxt = IDENT;
`endif
    end

    // Load sequencer: half toggle, flat address walk, and the done pulse.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ld_addr   <= '0;
            ld_half   <= 1'b0;
            ld_done_r <= 1'b0;
        end else begin
            ld_done_r <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (bus.ld_start) begin
                        state   <= ST_LOAD;
                        ld_addr <= '0;
                        ld_half <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_start) begin
                        ld_addr <= '0;
                        ld_half <= 1'b0;
                    end else if (bus.ld_valid) begin
                        if (!ld_half) begin
                            ld_half <= 1'b1;
                        end else begin
                            ld_half <= 1'b0;
                            if (ld_addr == LA_W'(TOTAL - 1)) begin
                                state     <= ST_RUN;
                                ld_done_r <= 1'b1;
                                ld_addr   <= '0;
                            end else begin
                                ld_addr <= ld_addr + LA_W'(1);
                            end
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Table storage: reset to identity, hi half then lo half per entry.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) entry_mem[i] <= IDENT;
        end else if (wr_en && (ld_addr < LA_W'(ENTRIES))) begin
            if (!ld_half) entry_mem[AW'(ld_addr)][P_WIDTH-1:DW] <= bus.ld_data;
            else          entry_mem[AW'(ld_addr)][DW-1:0]       <= bus.ld_data;
        end
    end

`ifdef TW_BUF_CONST_LOAD_EN
    // Per-stage constants occupy the addresses after the table.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGE; s++) const_mem[s] <= IDENT;
        end else if (wr_en && (ld_addr >= LA_W'(ENTRIES))) begin
            if (!ld_half) const_mem[const_sel][P_WIDTH-1:DW] <= bus.ld_data;
            else          const_mem[const_sel][DW-1:0]       <= bus.ld_data;
        end
    end
`endif

    // Replay: registered outputs plus idx/pass/group counters; adv low parks
    // the pass at its start, group rotation is kept per stage.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            q_r       <= IDENT;
            q_valid_r <= 1'b0;
            q_const_r <= IDENT;
            idx       <= '0;
            pass      <= '0;
            stage_q   <= '0;
            for (int s = 0; s < NUM_STAGE; s++) grp[s] <= '0;
        end else if (rd_en) begin
            q_r       <= entry_mem[rd_addr];
            q_valid_r <= 1'b1;
            q_const_r <= const_nxt;
            stage_q   <= bus.stage_counter;
            if (bus.adv) begin
                if (idx_eff == IDX_W'(DEPTH - 1)) begin
                    idx <= '0;
                    if (pass_eff == PASS_W'(REPEAT - 1)) begin
                        pass <= '0;
                        grp[stage_sel] <= (grp_cur == GRP_W'(NUM_GROUP - 1)) ? '0
                                                                            : grp_cur + GRP_W'(1);
                    end else begin
                        pass <= pass_eff + PASS_W'(1);
                    end
                end else begin
                    idx  <= idx_eff + IDX_W'(1);
                    pass <= pass_eff;
                end
            end else begin
                idx  <= '0;
                pass <= '0;
            end
        end else begin
            q_r       <= IDENT;
            q_valid_r <= 1'b0;
        end
    end

    assign bus.Q       = q_r;
    assign bus.Q_valid = q_valid_r;
    assign bus.Q_const = q_const_r;
    assign bus.ld_done = ld_done_r;

endmodule

// File: tb/tb_tw_buf_seq_param.sv
// Directed bench for tw_buf_seq_param with default parameters.
module tb_tw_buf_seq_param;
    localparam int ENTRIES = 48;
`ifdef TW_BUF_CONST_LOAD_EN
    localparam int TOTAL = ENTRIES + 3;
`else
    localparam int TOTAL = ENTRIES;
`endif
    localparam logic [127:0] IDENT = {64'd1, 64'd1};
    localparam logic [63:0]  ONES  = '1;
    localparam logic [63:0]  X2    = 64'h5555;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    tw_buf_seq_param_if #(.DW(64), .SC_WIDTH(2)) bus ();

    tw_buf_seq_param #(
        .DW(64), .NUM_STAGE(3), .NUM_GROUP(4), .DEPTH(4), .REPEAT(16)
    ) dut (
        .CLK  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] ent(input int a, input logic [63:0] off, input logic [63:0] lx);
        logic [63:0] h;
        h = 64'(a) + off;
        return {h, h ^ lx};
    endfunction

    function automatic logic [127:0] cst(input int s);
`ifdef TW_BUF_CONST_LOAD_EN
        return {64'(s), 64'(s)};
`else
        return (s >= 0) ? IDENT : IDENT;
`endif
    endfunction

    // Full load from address 0: hi = a+off, lo = hi^lx; constants {c,c}.
    // An idle cycle is inserted before every gap-th half-word when gap > 0.
    task automatic load_tbl(input logic [63:0] off, input logic [63:0] lx, input int gap,
                            output int done_cnt, output int q_bad);
        int n;
        logic [127:0] v;
        done_cnt = 0;
        q_bad    = 0;
        n        = 0;
        for (int a = 0; a < TOTAL; a++) begin
            v = (a < ENTRIES) ? ent(a, off, lx) : {64'(a - ENTRIES), 64'(a - ENTRIES)};
            for (int h = 0; h < 2; h++) begin
                if (gap > 0 && (n % gap) == gap - 1) begin
                    bus.ld_valid = 1'b0;
                    tick();
                    done_cnt += int'(bus.ld_done);
                    if (bus.Q !== IDENT || bus.Q_valid !== 1'b0) q_bad++;
                end
                bus.ld_valid = 1'b1;
                bus.ld_data  = (h == 0) ? v[127:64] : v[63:0];
                tick();
                done_cnt += int'(bus.ld_done);
                if (bus.Q !== IDENT || bus.Q_valid !== 1'b0) q_bad++;
                n++;
            end
        end
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        int dc, qb, a;
        rst_n             = 1'b0;
        bus.CEN           = 1'b1;
        bus.stage_counter = '0;
        bus.adv           = 1'b0;
        bus.ld_start      = 1'b0;
        bus.ld_valid      = 1'b0;
        bus.ld_data       = '0;
        tick();
        tick();
        chk("rst_q", bus.Q, IDENT);
        chk("rst_qv", 128'(bus.Q_valid), 128'(0));
        chk("rst_qc", bus.Q_const, IDENT);
        chk("rst_done", 128'(bus.ld_done), 128'(0));
        rst_n = 1'b1;

        // first load: hi = a, lo = ~a
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        load_tbl(64'd0, ONES, 0, dc, qb);
        chk("ld1_done_now", 128'(bus.ld_done), 128'(1));
        chk("ld1_done_cnt", 128'(dc), 128'(1));
        chk("ld1_q_ident", 128'(qb), 128'(0));

        // stage0 walk, 66 reads: crosses one group boundary, ends mid-pass at idx 2
        bus.CEN = 1'b0;
        bus.adv = 1'b1;
        bus.stage_counter = 2'd0;
        for (int k = 0; k < 66; k++) begin
            tick();
            a = ((k / 64) % 4) * 4 + (k % 4);
            chk($sformatf("s0_rd%0d", k), bus.Q, ent(a, 64'd0, ONES));
            if (k == 0) begin
                chk("s0_qv", 128'(bus.Q_valid), 128'(1));
                chk("s0_done_low", 128'(bus.ld_done), 128'(0));
            end
        end
        chk("s0_qc", bus.Q_const, cst(0));

        // stage switch 0 -> 2 mid-pass, then back to 0 (grp0 stays at 1)
        bus.stage_counter = 2'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("s2_rd%0d", k), bus.Q, ent(32 + k, 64'd0, ONES));
        end
        chk("s2_qc", bus.Q_const, cst(2));
        bus.stage_counter = 2'd0;
        tick();
        chk("s0b_rd0", bus.Q, ent(4, 64'd0, ONES));
        tick();
        chk("s0b_rd1", bus.Q, ent(5, 64'd0, ONES));

        // adv low: reads current idx then parks at 0
        bus.adv = 1'b0;
        tick();
        chk("adv0_rd", bus.Q, ent(6, 64'd0, ONES));
        bus.adv = 1'b1;
        tick();
        chk("adv1_rd", bus.Q, ent(4, 64'd0, ONES));

        // stage1: 257 reads walk groups 0..3 and back to 0
        bus.stage_counter = 2'd1;
        for (int k = 0; k < 257; k++) begin
            tick();
            a = 16 + ((k / 64) % 4) * 4 + (k % 4);
            chk($sformatf("s1_rd%0d", k), bus.Q, ent(a, 64'd0, ONES));
        end

        // out-of-range stage and CEN high give identity; Q_const holds
        bus.stage_counter = 2'd3;
        tick();
        chk("oor_q", bus.Q, IDENT);
        chk("oor_qv", 128'(bus.Q_valid), 128'(0));
        chk("oor_qc", bus.Q_const, cst(1));
        bus.stage_counter = 2'd1;
        bus.CEN = 1'b1;
        tick();
        chk("cen_q", bus.Q, IDENT);
        chk("cen_qv", 128'(bus.Q_valid), 128'(0));

        // ld_start while reading stage1 (idx 1): this edge still reads
        bus.CEN = 1'b0;
        bus.ld_start = 1'b1;
        tick();
        chk("ldst_rd", bus.Q, ent(17, 64'd0, ONES));
        bus.ld_start = 1'b0;
        // garbage into the first entries, then restart the load at address 0
        for (int k = 0; k < 10; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 64'hDEAD_BEEF_0000_0000 + 64'(k);
            tick();
        end
        bus.ld_valid = 1'b0;
        chk("ld2_mid_q", bus.Q, IDENT);
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        load_tbl(64'd1000, X2, 3, dc, qb);
        chk("ld2_done_now", 128'(bus.ld_done), 128'(1));
        chk("ld2_done_cnt", 128'(dc), 128'(1));
        chk("ld2_q_ident", 128'(qb), 128'(0));
        tick();
        chk("ld2_rd18", bus.Q, ent(18, 64'd1000, X2));
        chk("ld2_done_low", 128'(bus.ld_done), 128'(0));
        tick();
        chk("ld2_rd19", bus.Q, ent(19, 64'd1000, X2));
        bus.stage_counter = 2'd0;
        tick();
        chk("ld2_s0_rd", bus.Q, ent(4, 64'd1000, X2));
        chk("ld2_s0_qc", bus.Q_const, cst(0));

        // reset mid-load discards everything
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 64'hAAAA;
        tick();
        tick();
        bus.ld_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2_rd", bus.Q, IDENT);
        chk("rst2_qv", 128'(bus.Q_valid), 128'(1));
        chk("rst2_qc", bus.Q_const, IDENT);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
